trojan_scan_bist: RTL and testbench

Synthesizable exhaustive-pattern built-in self-test for Trojan detection on small combinational benchmarks (c17-class and wider). Walks every input vector 0 to 2^IN_W-1 into a golden netlist and a suspect netlist in parallel, then compares their responses. Reports a mismatch count and the first failing vector and difference. Sits beside the golden/suspect pair in the evaluation wrapper and replaces per-design hand-written exhaustive benches.

---
 rtl/trojan_bist_pkg.sv | 21 ++
 rtl/trojan_scan_bist_if.sv | 34 +++
 rtl/trojan_bist_cmp.sv | 72 +++++++
 rtl/trojan_scan_bist.sv | 104 ++++++++++
 tb/tb_trojan_scan_bist.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trojan_bist_pkg.sv
// Shared types and limits for the exhaustive-pattern Trojan scan BIST.
package trojan_bist_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam int unsigned MaxInW    = 16;
  localparam int unsigned MaxOutW   = 32;
  localparam int unsigned MaxSettle = 255;
  localparam int unsigned SettleW   = $clog2(MaxSettle + 1);

  // Clocks from the start-accept edge to the rising edge of done for a full scan.
  function automatic int unsigned scan_len(input int unsigned in_w, input int unsigned settle);
    return (32'd1 << in_w) * (settle + 32'd1);
  endfunction

endpackage

// File: rtl/trojan_scan_bist_if.sv
// Stimulus/response and result bundle between the scan BIST and its evaluation wrapper.
interface trojan_scan_bist_if #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 16
);

  logic             start;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] golden_resp;
  logic [OUT_W-1:0] dut_resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_fail_valid;
  logic [IN_W-1:0]  first_fail_vec;
  logic [OUT_W-1:0] first_fail_diff;

  // BIST side
  modport master (
    input  start, golden_resp, dut_resp,
    output stim, busy, done, pass, mismatch_cnt,
    output first_fail_valid, first_fail_vec, first_fail_diff
  );

  // Wrapper side
  modport slave (
    output start, golden_resp, dut_resp,
    input  stim, busy, done, pass, mismatch_cnt,
    input  first_fail_valid, first_fail_vec, first_fail_diff
  );

endinterface

// File: rtl/trojan_bist_cmp.sv
// Response comparator: XOR diff, saturating mismatch counter and first-failure capture.
module trojan_bist_cmp #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             strobe_i,
  input  logic [IN_W-1:0]  stim_i,
  input  logic [OUT_W-1:0] golden_i,
  input  logic [OUT_W-1:0] dut_i,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ff_valid_o,
  output logic [IN_W-1:0]  ff_vec_o,
  output logic [OUT_W-1:0] ff_diff_o
);

  logic [OUT_W-1:0] diff;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ff_valid_q, ff_valid_d;
  logic [IN_W-1:0]  ff_vec_q, ff_vec_d;
  logic [OUT_W-1:0] ff_diff_q, ff_diff_d;

  assign diff = golden_i ^ dut_i;
  // X/Z bits only register as a mismatch when the reduction resolves to 1.
  assign mismatch_o = |diff;

  always_comb begin
    cnt_d      = cnt_q;
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    ff_diff_d  = ff_diff_q;
    if (clr_i) begin
      cnt_d      = '0;
      ff_valid_d = 1'b0;
      ff_vec_d   = '0;
      ff_diff_d  = '0;
    end else if (strobe_i && mismatch_o) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (!ff_valid_q) begin
        ff_valid_d = 1'b1;
        ff_vec_d   = stim_i;
        ff_diff_d  = diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_diff_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
      ff_diff_q  <= ff_diff_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign ff_valid_o = ff_valid_q;
  assign ff_vec_o   = ff_vec_q;
  assign ff_diff_o  = ff_diff_q;

endmodule

// File: rtl/trojan_scan_bist.sv
// Exhaustive-pattern BIST: walks stim 0..2^IN_W-1 into golden/suspect netlists and compares.
// Build option TROJAN_SCAN_STOP_ON_FAIL_EN ends the scan at the first mismatching vector.
module trojan_scan_bist
  import trojan_bist_pkg::*;
#(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  trojan_scan_bist_if.master bus
);

  localparam logic [SettleW-1:0] SettleLd  = SettleW'(SETTLE);
  localparam state_e             LoadState = (SETTLE != 0) ? StSettle : StCompare;

`ifdef TROJAN_SCAN_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [IN_W-1:0]    stim_q, stim_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic               clr, strobe, mismatch;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    clr      = 1'b0;
    strobe   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          clr      = 1'b1;
          stim_d   = '0;
          settle_d = SettleLd;
          state_d  = LoadState;
        end
      end
      StSettle: begin
        settle_d = settle_q - SettleW'(1);
        if (settle_q == SettleW'(1)) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        strobe = 1'b1;
        // Terminating on the all-ones compare keeps stim from ever wrapping.
        if ((StopOnFail && mismatch) || (stim_q == '1)) begin
          state_d = StDone;
        end else begin
          stim_d   = stim_q + IN_W'(1);
          settle_d = SettleLd;
          state_d  = LoadState;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stim_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
    end
  end

  trojan_bist_cmp #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .strobe_i   (strobe),
    .stim_i     (stim_q),
    .golden_i   (bus.golden_resp),
    .dut_i      (bus.dut_resp),
    .mismatch_o (mismatch),
    .cnt_o      (cnt),
    .ff_valid_o (bus.first_fail_valid),
    .ff_vec_o   (bus.first_fail_vec),
    .ff_diff_o  (bus.first_fail_diff)
  );

  assign bus.stim         = stim_q;
  assign bus.busy         = (state_q == StSettle) || (state_q == StCompare);
  assign bus.done         = (state_q == StDone);
  assign bus.pass         = (state_q == StDone) && (cnt == '0);
  assign bus.mismatch_cnt = cnt;

endmodule

// File: tb/tb_trojan_scan_bist.sv
// Directed bench for trojan_scan_bist using c17 golden/suspect models (SETTLE=1, IN_W=5).
module tb_trojan_scan_bist;
  import trojan_bist_pkg::*;

`ifdef TROJAN_SCAN_STOP_ON_FAIL_EN
  localparam int ExpM2Cyc  = 8;
  localparam int ExpM2Cnt  = 1;
  localparam int ExpM2Stim = 3;
  localparam int ExpSatCyc = 2;
  localparam int ExpSatCnt = 1;
  localparam int ExpSatStm = 0;
  localparam int AbortMode = 0;
`else
  localparam int ExpM2Cyc  = 64;
  localparam int ExpM2Cnt  = 2;
  localparam int ExpM2Stim = 31;
  localparam int ExpSatCyc = 64;
  localparam int ExpSatCnt = 7;
  localparam int ExpSatStm = 31;
  localparam int AbortMode = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   mode_a   = 0;

  always #5 clk = ~clk;

  trojan_scan_bist_if #(.IN_W(5), .OUT_W(2), .CNT_W(16)) bus_a ();
  trojan_scan_bist_if #(.IN_W(5), .OUT_W(2), .CNT_W(3))  bus_b ();

  trojan_scan_bist #(.IN_W(5), .OUT_W(2), .SETTLE(1), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  trojan_scan_bist #(.IN_W(5), .OUT_W(2), .SETTLE(1), .CNT_W(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  // c17 with stim[0..4] = N1,N2,N3,N6,N7; response = {N22, N23}.
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {n22, n23};
  endfunction

  always_comb begin
    bus_a.golden_resp = c17(bus_a.stim);
    bus_a.dut_resp    = c17(bus_a.stim);
    if (mode_a == 1 && bus_a.stim == 5'h1f) bus_a.dut_resp[1] = ~bus_a.dut_resp[1];
    if (mode_a == 2 && (bus_a.stim == 5'h03 || bus_a.stim == 5'h11))
      bus_a.dut_resp[0] = ~bus_a.dut_resp[0];
    bus_b.golden_resp = c17(bus_b.stim);
    bus_b.dut_resp    = ~c17(bus_b.stim);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_a();
    return 64'({bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.mismatch_cnt,
                bus_a.first_fail_valid, bus_a.first_fail_vec, bus_a.first_fail_diff});
  endfunction

  function automatic logic [63:0] all_b();
    return 64'({bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.mismatch_cnt,
                bus_b.first_fail_valid, bus_b.first_fail_vec, bus_b.first_fail_diff});
  endfunction

  // Pulses start, then counts edges from the accept edge until done; optionally
  // re-pulses start while stim equals pulse_vec.
  task automatic do_scan(input bit use_b, input int pulse_vec, output int cyc,
                         output logic [15:0] acc_cnt, output logic acc_ffv,
                         output logic acc_done);
    bit         pulsed;
    logic       d;
    logic [4:0] s;
    pulsed = 1'b0;
    @(negedge clk);
    if (use_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    acc_cnt  = use_b ? 16'(bus_b.mismatch_cnt) : bus_a.mismatch_cnt;
    acc_ffv  = use_b ? bus_b.first_fail_valid : bus_a.first_fail_valid;
    acc_done = use_b ? bus_b.done : bus_a.done;
    cyc = 0;
    d   = acc_done;
    while (!d && cyc < 5000) begin
      s = use_b ? bus_b.stim : bus_a.stim;
      if (pulse_vec >= 0 && !pulsed && int'(s) == pulse_vec) begin
        if (use_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      cyc++;
      d = use_b ? bus_b.done : bus_a.done;
    end
    chk("scan_bounded", 64'(cyc < 5000), 64'd1);
  endtask

  initial begin
    int          cyc;
    int          n;
    logic [15:0] acc_cnt;
    logic        acc_ffv, acc_done;

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_zero", all_a(), 64'd0);
    chk("reset_b_zero", all_b(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_a_zero", all_a(), 64'd0);

    // Matching netlists
    mode_a = 0;
    do_scan(1'b0, -1, cyc, acc_cnt, acc_ffv, acc_done);
    chk("m0_latency", 64'(cyc), 64'd64);
    chk("m0_pass", 64'(bus_a.pass), 64'd1);
    chk("m0_cnt", 64'(bus_a.mismatch_cnt), 64'd0);
    chk("m0_ffv", 64'(bus_a.first_fail_valid), 64'd0);
    chk("m0_busy", 64'(bus_a.busy), 64'd0);
    chk("m0_stim_last", 64'(bus_a.stim), 64'h1f);

    // N22 flipped only on the all-ones vector
    mode_a = 1;
    do_scan(1'b0, -1, cyc, acc_cnt, acc_ffv, acc_done);
    chk("m1_latency", 64'(cyc), 64'd64);
    chk("m1_cnt", 64'(bus_a.mismatch_cnt), 64'd1);
    chk("m1_ffv", 64'(bus_a.first_fail_valid), 64'd1);
    chk("m1_ffvec", 64'(bus_a.first_fail_vec), 64'h1f);
    chk("m1_ffdiff", 64'(bus_a.first_fail_diff), 64'b10);
    chk("m1_pass", 64'(bus_a.pass), 64'd0);

    // N23 corrupted on 0x03 and 0x11; start from DONE must clear old results
    mode_a = 2;
    do_scan(1'b0, -1, cyc, acc_cnt, acc_ffv, acc_done);
    chk("m2_accept_cnt_clr", 64'(acc_cnt), 64'd0);
    chk("m2_accept_ffv_clr", 64'(acc_ffv), 64'd0);
    chk("m2_accept_done_clr", 64'(acc_done), 64'd0);
    chk("m2_latency", 64'(cyc), 64'(ExpM2Cyc));
    chk("m2_cnt", 64'(bus_a.mismatch_cnt), 64'(ExpM2Cnt));
    chk("m2_ffvec", 64'(bus_a.first_fail_vec), 64'h03);
    chk("m2_ffdiff", 64'(bus_a.first_fail_diff), 64'b01);
    chk("m2_stim_last", 64'(bus_a.stim), 64'(ExpM2Stim));
    chk("m2_pass", 64'(bus_a.pass), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("m2_hold_done", 64'(bus_a.done), 64'd1);
    chk("m2_hold_cnt", 64'(bus_a.mismatch_cnt), 64'(ExpM2Cnt));

    // CNT_W=3, every vector mismatches
    do_scan(1'b1, -1, cyc, acc_cnt, acc_ffv, acc_done);
    chk("sat_latency", 64'(cyc), 64'(ExpSatCyc));
    chk("sat_cnt", 64'(bus_b.mismatch_cnt), 64'(ExpSatCnt));
    chk("sat_ffvec", 64'(bus_b.first_fail_vec), 64'd0);
    chk("sat_ffdiff", 64'(bus_b.first_fail_diff), 64'b11);
    chk("sat_stim_last", 64'(bus_b.stim), 64'(ExpSatStm));
    chk("sat_pass", 64'(bus_b.pass), 64'd0);

    // start re-pulsed at vector 4 while busy must be ignored
    mode_a = 0;
    do_scan(1'b0, 4, cyc, acc_cnt, acc_ffv, acc_done);
    chk("busy_start_latency", 64'(cyc), 64'd64);
    chk("busy_start_pass", 64'(bus_a.pass), 64'd1);

    // Reset mid-scan at vector 10
    mode_a = AbortMode;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    n = 0;
    while (bus_a.stim != 5'd10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_vec10", 64'(n < 200), 64'd1);
    chk("abort_busy_before", 64'(bus_a.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_a_zero", all_a(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode_a = 1;
    do_scan(1'b0, -1, cyc, acc_cnt, acc_ffv, acc_done);
    chk("fresh_latency", 64'(cyc), 64'd64);
    chk("fresh_cnt", 64'(bus_a.mismatch_cnt), 64'd1);
    chk("fresh_ffvec", 64'(bus_a.first_fail_vec), 64'h1f);
    chk("fresh_ffdiff", 64'(bus_a.first_fail_diff), 64'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
